data_mem_pipe: RTL and testbench

Parametrised data memory for the GPU datapath, successor to the fixed 64-bit, 1024-word data BRAM. Adds:
- configurable word width, depth and read latency (1 or 2);
- byte-enable stores;
- write-first forwarding on same-cycle load/store collisions;
- a load-valid strobe;
- alignment and range checking with sticky error capture.

It sits at the MEM stage, fed by the load/store unit, and maps to one simple-dual-port block RAM.

---
 rtl/gpu_mem_pkg.sv | 22 ++
 rtl/bram_sdp_be.sv | 27 ++
 rtl/data_mem_pipe.sv | 135 +++++++++++++
 tb/tb_data_mem_pipe.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/gpu_mem_pkg.sv
// Shared address constants and helpers for the GPU data-memory path.
package gpu_mem_pkg;

    localparam int ADDR_W = 32;

    function automatic logic [ADDR_W-1:0] word_idx(input logic [ADDR_W-1:0] addr,
                                                   input int unsigned off_w);
        return addr >> off_w;
    endfunction

    // Legal means word-aligned and inside the DEPTH*BYTES byte window.
    function automatic logic is_legal(input logic [ADDR_W-1:0] addr,
                                      input int unsigned depth,
                                      input int unsigned bytes);
        logic [63:0] limit;
        logic [ADDR_W-1:0] mask;
        limit = 64'(depth) * 64'(bytes);
        mask  = ADDR_W'(bytes - 1);
        return ((addr & mask) == '0) && (64'(addr) < limit);
    endfunction

endpackage

// File: rtl/bram_sdp_be.sv
// Simple-dual-port RAM with per-byte write enables and a registered read port.
module bram_sdp_be #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024
) (
    input  logic                       clk,
    input  logic [DATA_W/8-1:0]        we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_W-1:0]          rdata
);

    localparam int BYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Read-first on same-address collisions; the top level forwards store bytes.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/data_mem_pipe.sv
// MEM-stage data memory: byte-enable stores, write-first forwarding, error capture.
module data_mem_pipe
    import gpu_mem_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_en,
    input  logic [31:0]         ld_addr,
    output logic [DATA_W-1:0]   ld_data,
    output logic                ld_valid,
    output logic                ld_err,
    input  logic                st_en,
    input  logic [31:0]         st_addr,
    input  logic [DATA_W-1:0]   st_data,
    input  logic [DATA_W/8-1:0] st_be,
    output logic                st_err,
    output logic                err_sticky,
    output logic [31:0]         err_addr
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);

    logic             ld_legal, st_legal, ld_bad, st_bad, collide;
    logic [IDX_W-1:0] ld_idx, st_idx;
    logic [BYTES-1:0] ram_we;
    logic [DATA_W-1:0] ram_rdata;

    always_comb begin
        ld_legal = is_legal(ld_addr, DEPTH, BYTES);
        st_legal = is_legal(st_addr, DEPTH, BYTES);
        ld_idx   = IDX_W'(word_idx(ld_addr, OFF_W));
        st_idx   = IDX_W'(word_idx(st_addr, OFF_W));
        ld_bad   = ld_en && !ld_legal;
        st_bad   = st_en && !st_legal;
        collide  = ld_en && ld_legal && st_en && st_legal && (ld_idx == st_idx);
        ram_we   = (st_en && st_legal) ? st_be : '0;
    end

    bram_sdp_be #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (st_idx),
        .wdata (st_data),
        .re    (ld_en && ld_legal),
        .raddr (ld_idx),
        .rdata (ram_rdata)
    );

    // Stage-1 side info; only reloaded on a load so the merged word holds between loads.
    logic              v1, e1, z1, c1;
    logic [BYTES-1:0]  be1;
    logic [DATA_W-1:0] fd1, m1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1  <= 1'b0;
            e1  <= 1'b0;
            z1  <= 1'b1;
            c1  <= 1'b0;
            be1 <= '0;
            fd1 <= '0;
        end else begin
            v1 <= ld_en;
            if (ld_en) begin
                e1  <= !ld_legal;
                z1  <= !ld_legal;
                c1  <= collide;
                be1 <= st_be;
                fd1 <= st_data;
            end
        end
    end

    always_comb begin
        m1 = ram_rdata;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (c1 && be1[i]) m1[8*i +: 8] = fd1[8*i +: 8];
        end
        if (z1) m1 = '0;
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              v2, e2;
            logic [DATA_W-1:0] d2;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v2 <= 1'b0;
                    e2 <= 1'b0;
                    d2 <= '0;
                end else begin
                    v2 <= v1;
                    if (v1) begin
                        e2 <= e1;
                        d2 <= m1;
                    end
                end
            end

            assign ld_data  = d2;
            assign ld_valid = v2;
            assign ld_err   = v2 && e2;
        end else begin : g_lat1
            assign ld_data  = m1;
            assign ld_valid = v1;
            assign ld_err   = v1 && e1;
        end
    endgenerate

    // A store error in the same cycle as a load error takes priority for err_addr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_err     <= 1'b0;
            err_sticky <= 1'b0;
            err_addr   <= '0;
        end else begin
            st_err <= st_bad;
            if (!err_sticky && (st_bad || ld_bad)) begin
                err_sticky <= 1'b1;
                err_addr   <= st_bad ? st_addr : ld_addr;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed bench for data_mem_pipe at RD_LAT=1 and RD_LAT=2.
module tb_data_mem_pipe;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic        a_ld_en, a_st_en, a_ld_valid, a_ld_err, a_st_err, a_sticky;
    logic [31:0] a_ld_addr, a_st_addr, a_err_addr;
    logic [63:0] a_ld_data, a_st_data;
    logic [7:0]  a_st_be;

    logic        b_ld_en, b_st_en, b_ld_valid, b_ld_err, b_st_err, b_sticky;
    logic [31:0] b_ld_addr, b_st_addr, b_err_addr;
    logic [63:0] b_ld_data, b_st_data;
    logic [7:0]  b_st_be;

    int checks = 0;
    int errors = 0;

    data_mem_pipe #(.DATA_W(64), .DEPTH(1024), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst),
        .ld_en(a_ld_en), .ld_addr(a_ld_addr), .ld_data(a_ld_data),
        .ld_valid(a_ld_valid), .ld_err(a_ld_err),
        .st_en(a_st_en), .st_addr(a_st_addr), .st_data(a_st_data), .st_be(a_st_be),
        .st_err(a_st_err), .err_sticky(a_sticky), .err_addr(a_err_addr)
    );

    data_mem_pipe #(.DATA_W(64), .DEPTH(1024), .RD_LAT(2)) dut_b (
        .clk(clk), .rst(rst),
        .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data),
        .ld_valid(b_ld_valid), .ld_err(b_ld_err),
        .st_en(b_st_en), .st_addr(b_st_addr), .st_data(b_st_data), .st_be(b_st_be),
        .st_err(b_st_err), .err_sticky(b_sticky), .err_addr(b_err_addr)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        {a_ld_en, a_st_en, b_ld_en, b_st_en} = '0;
        {a_ld_addr, a_st_addr, b_ld_addr, b_st_addr} = '0;
        {a_st_data, b_st_data} = '0;
        {a_st_be, b_st_be} = '0;
        #1 rst = 1'b1;
        #1;
        chk("rst_ld_data",  a_ld_data, 64'h0);
        chk("rst_ld_valid", 64'(a_ld_valid), 64'h0);
        chk("rst_ld_err",   64'(a_ld_err), 64'h0);
        chk("rst_st_err",   64'(a_st_err), 64'h0);
        chk("rst_sticky",   64'(a_sticky), 64'h0);
        chk("rst_err_addr", 64'(a_err_addr), 64'h0);
        cyc(); cyc();
        rst = 1'b0;

        // RD_LAT=1: preload word 0, then full store / load at 0x40
        a_st_en = 1; a_st_addr = 32'h0; a_st_data = 64'h0123456789ABCDEF; a_st_be = 8'hFF;
        cyc();
        a_st_addr = 32'h40; a_st_data = 64'h1122334455667788;
        cyc();
        a_st_en = 0; a_ld_en = 1; a_ld_addr = 32'h40;
        cyc();
        a_ld_en = 0;
        chk("full_valid", 64'(a_ld_valid), 64'h1);
        chk("full_data",  a_ld_data, 64'h1122334455667788);
        chk("full_err",   64'(a_ld_err), 64'h0);
        cyc();
        chk("strobe_low", 64'(a_ld_valid), 64'h0);
        chk("data_hold",  a_ld_data, 64'h1122334455667788);

        a_st_en = 1; a_st_addr = 32'h40; a_st_data = 64'hAAAAAAAAAAAAAAAA; a_st_be = 8'h0F;
        cyc();
        a_st_en = 0; a_ld_en = 1; a_ld_addr = 32'h40;
        cyc();
        a_ld_en = 0;
        chk("partial_data", a_ld_data, 64'h11223344AAAAAAAA);

        a_st_en = 1; a_st_addr = 32'h40; a_st_data = 64'hFFFFFFFFFFFFFFFF; a_st_be = 8'hF0;
        a_ld_en = 1; a_ld_addr = 32'h40;
        cyc();
        a_st_en = 0; a_ld_en = 0;
        chk("coll_valid", 64'(a_ld_valid), 64'h1);
        chk("coll_data",  a_ld_data, 64'hFFFFFFFFAAAAAAAA);
        a_ld_en = 1;
        cyc();
        a_ld_en = 0;
        chk("coll_mem", a_ld_data, 64'hFFFFFFFFAAAAAAAA);

        a_ld_en = 1; a_ld_addr = 32'h43;
        cyc();
        a_ld_en = 0;
        chk("mis_valid",    64'(a_ld_valid), 64'h1);
        chk("mis_err",      64'(a_ld_err), 64'h1);
        chk("mis_data",     a_ld_data, 64'h0);
        chk("mis_sticky",   64'(a_sticky), 64'h1);
        chk("mis_err_addr", 64'(a_err_addr), 64'h43);
        cyc();
        chk("mis_err_low", 64'(a_ld_err), 64'h0);

        a_st_en = 1; a_st_addr = 32'h2000; a_st_data = 64'hDEADBEEFDEADBEEF; a_st_be = 8'hFF;
        cyc();
        a_st_en = 0;
        chk("oor_st_err",   64'(a_st_err), 64'h1);
        chk("oor_err_addr", 64'(a_err_addr), 64'h43);
        a_ld_en = 1; a_ld_addr = 32'h0;
        cyc();
        a_ld_en = 0;
        chk("oor_st_pulse", 64'(a_st_err), 64'h0);
        chk("oor_no_write", a_ld_data, 64'h0123456789ABCDEF);
        chk("oor_ld_ok",    64'(a_ld_err), 64'h0);

        // RD_LAT=2: back-to-back loads
        b_st_en = 1; b_st_be = 8'hFF;
        b_st_addr = 32'h0;  b_st_data = 64'h1000000000000001; cyc();
        b_st_addr = 32'h8;  b_st_data = 64'h2000000000000002; cyc();
        b_st_addr = 32'h10; b_st_data = 64'h3000000000000003; cyc();
        b_st_en = 0;
        b_ld_en = 1; b_ld_addr = 32'h0;
        cyc();
        chk("l2_lat_gap", 64'(b_ld_valid), 64'h0);
        b_ld_addr = 32'h8;
        cyc();
        chk("l2_v0", 64'(b_ld_valid), 64'h1);
        chk("l2_d0", b_ld_data, 64'h1000000000000001);
        b_ld_addr = 32'h10;
        cyc();
        b_ld_en = 0;
        chk("l2_v1", 64'(b_ld_valid), 64'h1);
        chk("l2_d1", b_ld_data, 64'h2000000000000002);
        cyc();
        chk("l2_v2", 64'(b_ld_valid), 64'h1);
        chk("l2_d2", b_ld_data, 64'h3000000000000003);
        cyc();
        chk("l2_end", 64'(b_ld_valid), 64'h0);
        chk("l2_hold", b_ld_data, 64'h3000000000000003);

        // Store after the load cycle must not alter the in-flight result
        b_ld_en = 1; b_ld_addr = 32'h8;
        cyc();
        b_ld_en = 0; b_st_en = 1; b_st_addr = 32'h8; b_st_data = 64'h5555555555555555;
        cyc();
        b_st_en = 0;
        chk("l2_late_st", b_ld_data, 64'h2000000000000002);
        b_st_en = 1; b_st_data = 64'h2000000000000002;
        cyc();
        b_st_en = 0;

        // Reset with loads in flight
        b_ld_en = 1; b_ld_addr = 32'h0;
        cyc();
        b_ld_addr = 32'h8;
        cyc();
        b_ld_en = 0;
        rst = 1'b1;
        #1;
        chk("rst2_valid", 64'(b_ld_valid), 64'h0);
        chk("rst2_data",  b_ld_data, 64'h0);
        chk("rst2_err",   64'(b_ld_err), 64'h0);
        chk("rst2_sterr", 64'(b_st_err), 64'h0);
        chk("rst2_a_sticky", 64'(a_sticky), 64'h0);
        cyc(); cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rst2_no_valid", 64'(b_ld_valid), 64'h0);
        end
        b_ld_en = 1; b_ld_addr = 32'h8;
        cyc();
        b_ld_addr = 32'h10;
        cyc();
        b_ld_en = 0;
        chk("kept_v", 64'(b_ld_valid), 64'h1);
        chk("kept_8", b_ld_data, 64'h2000000000000002);
        cyc();
        chk("kept_10", b_ld_data, 64'h3000000000000003);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
